// File: rtl/kara_pkg.sv
// Shared widths and FSM encoding for the Karatsuba recombination stage.
package kara_pkg;
   localparam int HALF_W = 64;
   localparam int PP_W   = 2 * HALF_W;
   localparam int MID_W  = 2 * HALF_W + 2;
   localparam int PROD_W = 4 * HALF_W;

   typedef enum logic [2:0] {
      IDLE,
      SUB1,
      SUB2,
      ADD,
      OUT
   } state_t;
endpackage

// File: rtl/adder_256bit.sv
// Plain ripple-carry adder used for the final recombination sum.
module adder_256bit
   import kara_pkg::*;
#(
   parameter int W = PROD_W
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   logic w_carry;

   always_comb begin
      o_sum   = '0;
      w_carry = i_cin;
      for (int i = 0; i < W; i++) begin
         o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
         w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
      end
      o_cout = w_carry;
   end

endmodule

// File: rtl/kara_combine_256.sv
// Sequential Karatsuba recombination: mid = zmid - z0 - z2 over two cycles,
// then product = z2*2^128 + mid*2^64 + z0 in one 256-bit adder pass.
module kara_combine_256
   import kara_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PP_W-1:0]   z0,
   input  logic [PP_W-1:0]   z2,
   input  logic [MID_W-1:0]  zmid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              err
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [PP_W-1:0]     r_z0;
   logic [PP_W-1:0]     r_z2;
   logic [MID_W-1:0]    r_mid;
   logic                r_borrow;
   logic                r_err;
   logic [PROD_W-1:0]   r_product;

   logic [MID_W-1:0]    w_subtrahend;
   logic [MID_W:0]      w_diff;
   logic [PROD_W-1:0]   w_add_a;
   logic [PROD_W-1:0]   w_add_b;
   logic [PROD_W-1:0]   w_sum;
   logic                w_cout_unused;

   // Extra top bit of the result carries the borrow out of the subtraction.
   function automatic logic [MID_W:0] sub_with_borrow(input logic [MID_W-1:0] a,
                                                      input logic [MID_W-1:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

   // One shared subtractor: z0 is removed in SUB1, z2 in SUB2.
   assign w_subtrahend = (r_state == SUB1) ? {2'b00, r_z0} : {2'b00, r_z2};
   assign w_diff       = sub_with_borrow(r_mid, w_subtrahend);

   // mid[129] is dropped; it is only set when a borrow already flagged err.
   assign w_add_a = {r_z2, r_z0};
   assign w_add_b = {{(PROD_W - MID_W - HALF_W + 1){1'b0}}, r_mid[MID_W-2:0], {HALF_W{1'b0}}};

   adder_256bit #(
      .W (PROD_W)
   ) u_adder (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout_unused)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = SUB1;
         SUB1:    w_state_nxt = SUB2;
         SUB2:    w_state_nxt = ADD;
         ADD:     w_state_nxt = OUT;
         OUT:     if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so no input reaches them combinationally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == IDLE);
         r_out_valid <= (w_state_nxt == OUT);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_z0      <= '0;
         r_z2      <= '0;
         r_mid     <= '0;
         r_borrow  <= 1'b0;
         r_err     <= 1'b0;
         r_product <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_z0     <= z0;
                  r_z2     <= z2;
                  r_mid    <= zmid;
                  r_borrow <= 1'b0;
               end
            end
            SUB1, SUB2: begin
               r_mid    <= w_diff[MID_W-1:0];
               r_borrow <= r_borrow | w_diff[MID_W];
            end
            ADD: begin
               r_product <= w_sum;
               r_err     <= r_borrow;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign product   = r_product;
   assign err       = r_err;

endmodule
